wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Write-back end of the MEM/WB pipeline register: consumes the latched MEM/WB fields and selects the write-back value.
//  Owns the 32x32 register file; its two read ports serve the ID stage.
//  Handles syscall (display latch and halt) and keeps retirement statistics counters.
//  Sits between the MEM/WB register outputs and the ID stage register reads.
// PARAMETERS
//  HALT_CODE  32'd10  $v0 value that makes a syscall halt the machine
//  CNT_W      32      width of the statistics counters
// PORTS
//  in_CLK      in   1   clock; every state element updates on posedge
//  in_CLR      in   1   synchronous, active-high reset
//  in_EN       in   1   retire enable; 0 = pipeline stalled, nothing retires
//  in_is       in   32  instruction word from MEM/WB; 32'd0 = bubble
//  in_pcout    in   32  PC+4 of the instruction (JAL link value)
//  in_R        in   32  ALU result; [1:0] = byte offset for sub-word loads
//  in_Memdata  in   32  word read from data memory
//  in_p4       in   5   destination register number
//  in_control  in   23  [0] RegWrite, [1] MemToReg, [2] Jal, [3] Syscall,
//                       [5:4] load size (00 word, 01 half, 10 byte), [6] load unsigned
//  in_rd_a     in   5   read port A address (ID stage)
//  in_rd_b     in   5   read port B address (ID stage)
//  out_ra      out  32  read port A data
//  out_rb      out  32  read port B data
//  out_wb_data out  32  selected write-back value (combinational)
//  out_disp    out  32  display latch, loaded from $a0 by a non-halting syscall
//  out_halt    out  1   sticky halt flag
//  out_cycles  out  CNT_W  cycles since reset while not halted
//  out_retired out  CNT_W  retired non-bubble instructions
//  out_loads   out  CNT_W  retired loads (MemToReg=1)
// BEHAVIOUR
//  Reset (in_CLR=1 at posedge):
//   - out_halt, out_disp and all three counters go to 0.
//   - All 32 registers go to 0.
//   - in_CLR takes priority over in_EN and halt.
//  Retire condition: ret = in_EN & (in_is!=0) & ~out_halt.
//  Write-back select:
//   - Jal -> in_pcout.
//   - else MemToReg -> extracted load data.
//   - else in_R.
//  Load extraction:
//   - Byte: in_Memdata byte at offset in_R[1:0], little-endian (offset 0 = [7:0]).
//   - Half: half at in_R[1] (0 = [15:0]).
//   - Word: full word; in_R[1:0] is ignored.
//   - Sub-word values are sign-extended unless [6]=1, then zero-extended.
//   - Load size 11 is treated as word.
//  Register write:
//   - At posedge when ret & RegWrite & in_p4!=0, reg[in_p4] <= out_wb_data.
//   - Writes to reg0 are dropped; reg0 always reads 0.
//  Read ports:
//   - Combinational, with write-first bypass.
//   - If a write is enabled this cycle and in_rd_x == in_p4 != 0, out_rx = out_wb_data.
//   - Otherwise out_rx = reg[in_rd_x].
//  Syscall (ret & Syscall), using register values before this cycle's write:
//   - reg[2]==HALT_CODE: out_halt <= 1 at that posedge; the syscall counts as retired.
//   - otherwise: out_disp <= reg[4].
//   - A syscall with RegWrite=1 is illegal; no register write occurs.
//  Halt:
//   - Sticky until in_CLR.
//   - While halted: no register writes, no counter updates, out_disp frozen.
//   - Read ports stay live.
//  Counters:
//   - out_cycles +1 on every posedge while ~out_halt, including stalls.
//   - out_retired +1 when ret.
//   - out_loads +1 when ret & MemToReg.
//   - All counters wrap modulo 2^CNT_W and update in the halting cycle.
//  Latency:
//   - Register write visible to a non-bypassed read one cycle after the posedge.
//   - Bypassed read shows the value in the same cycle.
//  Stall (in_EN=0): inputs are ignored except the read ports; only out_cycles advances.
// TESTING
//  T1 reset: after in_CLR, out_ra/out_rb for all addresses, counters, out_halt and out_disp are 0.
//  T2 ALU write: in_p4=5, in_R=32'h1234, RegWrite=1 -> next cycle in_rd_a=5 gives 32'h1234;
//     same-cycle in_rd_b=5 gives 32'h1234 via bypass; out_retired=1.
//  T3 loads: in_Memdata=32'h80FF7F01, in_R[1:0]=1, byte signed -> 32'h0000007F;
//     in_R[1:0]=3, byte signed -> 32'hFFFFFF80; in_R[1]=1, half unsigned -> 32'h000080FF;
//     out_loads=3.
//  T4 reg0/JAL: RegWrite to p4=0 -> reg0 stays 0;
//     Jal, p4=31, in_pcout=32'h3004 -> reg31=32'h3004.
//  T5 syscall: reg2=1, reg4=32'hBEEF, syscall -> out_disp=32'hBEEF;
//     reg2=10, syscall -> out_halt=1; later RegWrite ignored and out_cycles frozen.
//  T6 stall/bubble/wrap: in_EN=0 with RegWrite -> no write, out_retired unchanged;
//     in_is=0 -> no retire; CNT_W=4 with 16 cycles -> out_cycles wraps to 0.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: selects the write-back value, owns the register file,
// handles syscall display/halt and keeps retirement statistics.
//
// Ports:
//   in_CLK, in_CLR      clock, synchronous active-high reset
//   in_EN               retire enable (0 = stall)
//   in_is               instruction word (0 = bubble)
//   in_pcout            link value for JAL
//   in_R                ALU result / load byte offset
//   in_Memdata          data memory word
//   in_p4               destination register
//   in_control          [0] RegWrite [1] MemToReg [2] Jal [3] Syscall
//                       [5:4] load size [6] load unsigned
//   in_rd_a, in_rd_b    ID-stage read addresses
//   out_ra, out_rb      read data (write-first bypass)
//   out_wb_data         selected write-back value
//   out_disp, out_halt  syscall display latch and sticky halt
//   out_cycles, out_retired, out_loads  statistics counters
module wb_stage #(
  parameter logic [31:0] HALT_CODE = 32'd10,
  parameter int          CNT_W     = 32
) (
  input  logic             in_CLK,
  input  logic             in_CLR,
  input  logic             in_EN,
  input  logic [31:0]      in_is,
  input  logic [31:0]      in_pcout,
  input  logic [31:0]      in_R,
  input  logic [31:0]      in_Memdata,
  input  logic [4:0]       in_p4,
  input  logic [22:0]      in_control,
  input  logic [4:0]       in_rd_a,
  input  logic [4:0]       in_rd_b,
  output logic [31:0]      out_ra,
  output logic [31:0]      out_rb,
  output logic [31:0]      out_wb_data,
  output logic [31:0]      out_disp,
  output logic             out_halt,
  output logic [CNT_W-1:0] out_cycles,
  output logic [CNT_W-1:0] out_retired,
  output logic [CNT_W-1:0] out_loads
);

  logic        reg_write;
  logic        mem_to_reg;
  logic        jal;
  logic        syscall;
  logic [1:0]  ld_size;
  logic        ld_uns;
  logic        unused_ctl;

  assign reg_write  = in_control[0];
  assign mem_to_reg = in_control[1];
  assign jal        = in_control[2];
  assign syscall    = in_control[3];
  assign ld_size    = in_control[5:4];
  assign ld_uns     = in_control[6];
  assign unused_ctl = ^in_control[22:7];

  logic [31:0] rf [32];

  logic        ret;
  logic        we;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign ret = in_EN & (in_is != 32'd0) & ~out_halt;
  // A syscall carrying RegWrite is illegal and must not write.
  assign we  = ret & reg_write & ~syscall & (in_p4 != 5'd0);

  always_comb begin
    ld_byte = in_Memdata[7:0];
    unique case (in_R[1:0])
      2'd0: ld_byte = in_Memdata[7:0];
      2'd1: ld_byte = in_Memdata[15:8];
      2'd2: ld_byte = in_Memdata[23:16];
      2'd3: ld_byte = in_Memdata[31:24];
    endcase
  end

  assign ld_half = in_R[1] ? in_Memdata[31:16]
                           : in_Memdata[15:0];

  always_comb begin
    ld_data = in_Memdata;
    case (ld_size)
      2'b01: ld_data = {{16{ld_half[15] & ~ld_uns}},
                        ld_half};
      2'b10: ld_data = {{24{ld_byte[7] & ~ld_uns}},
                        ld_byte};
      default: ld_data = in_Memdata;
    endcase
  end

  always_comb begin
    out_wb_data = in_R;
    if (jal)
      out_wb_data = in_pcout;
    else if (mem_to_reg)
      out_wb_data = ld_data;
  end

  assign out_ra = (we && in_rd_a == in_p4) ? out_wb_data
                                           : rf[in_rd_a];
  assign out_rb = (we && in_rd_b == in_p4) ? out_wb_data
                                           : rf[in_rd_b];

  always_ff @(posedge in_CLK) begin
    if (in_CLR) begin
      for (int i = 0; i < 32; i++)
        rf[i] <= 32'd0;
    end else if (we) begin
      rf[in_p4] <= out_wb_data;
    end
  end

  always_ff @(posedge in_CLK) begin
    if (in_CLR) begin
      out_halt <= 1'b0;
      out_disp <= 32'd0;
    end else if (ret && syscall) begin
      if (rf[2] == HALT_CODE)
        out_halt <= 1'b1;
      else
        out_disp <= rf[4];
    end
  end

  always_ff @(posedge in_CLK) begin
    if (in_CLR) begin
      out_cycles  <= '0;
      out_retired <= '0;
      out_loads   <= '0;
    end else begin
      if (!out_halt)
        out_cycles <= out_cycles + 1'b1;
      if (ret)
        out_retired <= out_retired + 1'b1;
      if (ret && mem_to_reg)
        out_loads <= out_loads + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios with literal expectations,
// then random traffic against a behavioural model.
module tb_wb_stage;

  logic        clk;
  logic        clr;
  logic        en;
  logic [31:0] is;
  logic [31:0] pcout;
  logic [31:0] r;
  logic [31:0] md;
  logic [4:0]  p4;
  logic [22:0] ctl;
  logic [4:0]  rd_a;
  logic [4:0]  rd_b;

  logic [31:0] ra, rb, wb, disp;
  logic        halt;
  logic [31:0] cyc_o, ret_o, lds_o;

  logic [31:0] ra4, rb4, wb4, disp4;
  logic        halt4;
  logic [3:0]  cyc4, ret4, lds4;

  wb_stage dut (
    .in_CLK(clk), .in_CLR(clr), .in_EN(en), .in_is(is),
    .in_pcout(pcout), .in_R(r), .in_Memdata(md),
    .in_p4(p4), .in_control(ctl),
    .in_rd_a(rd_a), .in_rd_b(rd_b),
    .out_ra(ra), .out_rb(rb), .out_wb_data(wb),
    .out_disp(disp), .out_halt(halt),
    .out_cycles(cyc_o), .out_retired(ret_o),
    .out_loads(lds_o)
  );

  wb_stage #(.CNT_W(4)) dut4 (
    .in_CLK(clk), .in_CLR(clr), .in_EN(en), .in_is(is),
    .in_pcout(pcout), .in_R(r), .in_Memdata(md),
    .in_p4(p4), .in_control(ctl),
    .in_rd_a(rd_a), .in_rd_b(rd_b),
    .out_ra(ra4), .out_rb(rb4), .out_wb_data(wb4),
    .out_disp(disp4), .out_halt(halt4),
    .out_cycles(cyc4), .out_retired(ret4),
    .out_loads(lds4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec = 0;
  int errs = 0;
  bit chk_en = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model
  logic [31:0] m_rf [32];
  logic        m_halt;
  logic [31:0] m_disp, m_cycles, m_ret, m_loads;

  function automatic logic [31:0] m_load();
    logic [31:0] v;
    int sh;
    if (ctl[5:4] == 2'b10) begin
      sh = 8 * int'(r[1:0]);
      v = (md >> sh) & 32'hFF;
      if (!ctl[6] && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (ctl[5:4] == 2'b01) begin
      sh = 16 * int'(r[1]);
      v = (md >> sh) & 32'hFFFF;
      if (!ctl[6] && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = md;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_wb();
    if (ctl[2]) return pcout;
    if (ctl[1]) return m_load();
    return r;
  endfunction

  function automatic bit m_retire();
    return en && is != 0 && !m_halt;
  endfunction

  function automatic bit m_we();
    return m_retire() && ctl[0] && !ctl[3] && p4 != 0;
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] a);
    if (m_we() && a == p4) return m_wb();
    return m_rf[a];
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) m_rf[i] <= 32'd0;
      m_halt <= 1'b0;
      m_disp <= 32'd0;
      m_cycles <= 32'd0;
      m_ret <= 32'd0;
      m_loads <= 32'd0;
    end else begin
      if (!m_halt) m_cycles <= m_cycles + 1;
      if (m_retire()) begin
        m_ret <= m_ret + 1;
        if (ctl[1]) m_loads <= m_loads + 1;
        if (ctl[3]) begin
          if (m_rf[2] == 32'd10) m_halt <= 1'b1;
          else m_disp <= m_rf[4];
        end
      end
      if (m_we()) m_rf[p4] <= m_wb();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("wb_data", wb, m_wb());
      chk("ra", ra, m_read(rd_a));
      chk("rb", rb, m_read(rd_b));
      chk("disp", disp, m_disp);
      chk("halt", {31'd0, halt}, {31'd0, m_halt});
      chk("cycles", cyc_o, m_cycles);
      chk("retired", ret_o, m_ret);
      chk("loads", lds_o, m_loads);
      chk("cycles4", {28'd0, cyc4}, {28'd0, m_cycles[3:0]});
      chk("retired4", {28'd0, ret4}, {28'd0, m_ret[3:0]});
      chk("loads4", {28'd0, lds4}, {28'd0, m_loads[3:0]});
    end
  end

  task automatic set(logic [22:0] c, logic [31:0] i,
                     logic [4:0] d, logic [31:0] rr,
                     logic [31:0] m, logic [31:0] pc,
                     logic [4:0] a, logic [4:0] b);
    ctl = c; is = i; p4 = d; r = rr;
    md = m; pcout = pc; rd_a = a; rd_b = b;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  logic [31:0] c0;

  initial begin
    clr = 1'b1;
    en = 1'b1;
    set(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk_en = 1;
    clr = 1'b0;

    // T1 reset state
    @(negedge clk);
    chk("t1_cycles", cyc_o, 32'd0);
    chk("t1_retired", ret_o, 32'd0);
    chk("t1_loads", lds_o, 32'd0);
    chk("t1_halt", {31'd0, halt}, 32'd0);
    chk("t1_disp", disp, 32'd0);
    step();
    for (int i = 0; i < 32; i++) begin
      set(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
      @(negedge clk);
      chk("t1_ra", ra, 32'd0);
      chk("t1_rb", rb, 32'd0);
      step();
    end

    // T2 ALU write with bypass
    set(23'h1, 1, 5, 32'h1234, 0, 0, 0, 5);
    @(negedge clk);
    chk("t2_bypass", rb, 32'h1234);
    step();
    set(0, 0, 0, 0, 0, 0, 5, 0);
    @(negedge clk);
    chk("t2_read", ra, 32'h1234);
    chk("t2_retired", ret_o, 32'd1);
    step();

    // T3 sub-word loads
    set(23'h23, 1, 6, 32'h1, 32'h80FF7F01, 0, 6, 0);
    @(negedge clk);
    chk("t3_byte1", wb, 32'h0000007F);
    step();
    set(23'h23, 1, 7, 32'h3, 32'h80FF7F01, 0, 0, 0);
    @(negedge clk);
    chk("t3_byte3", wb, 32'hFFFFFF80);
    step();
    set(23'h53, 1, 8, 32'h2, 32'h80FF7F01, 0, 0, 0);
    @(negedge clk);
    chk("t3_half_u", wb, 32'h000080FF);
    step();
    set(0, 0, 0, 0, 0, 0, 6, 8);
    @(negedge clk);
    chk("t3_loads", lds_o, 32'd3);
    chk("t3_r6", ra, 32'h0000007F);
    chk("t3_r8", rb, 32'h000080FF);
    step();

    // T4 reg0 and JAL
    set(23'h1, 1, 0, 32'hDEAD, 0, 0, 0, 0);
    @(negedge clk);
    chk("t4_r0_nobyp", ra, 32'd0);
    step();
    set(23'h5, 1, 31, 32'h9, 0, 32'h3004, 0, 31);
    @(negedge clk);
    chk("t4_jal_wb", wb, 32'h3004);
    step();
    set(0, 0, 0, 0, 0, 0, 0, 31);
    @(negedge clk);
    chk("t4_r0", ra, 32'd0);
    chk("t4_r31", rb, 32'h3004);
    step();

    // T5 syscall display, then halt
    set(23'h1, 1, 2, 32'd1, 0, 0, 0, 0);
    step();
    set(23'h1, 1, 4, 32'hBEEF, 0, 0, 0, 0);
    step();
    set(23'h8, 1, 0, 0, 0, 0, 0, 0);
    step();
    set(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t5_disp", disp, 32'hBEEF);
    chk("t5_nohalt", {31'd0, halt}, 32'd0);
    step();
    set(23'h1, 1, 2, 32'd10, 0, 0, 0, 0);
    step();
    set(23'h8, 1, 0, 0, 0, 0, 0, 0);
    step();
    set(23'h1, 1, 9, 32'h55, 0, 0, 9, 0);
    @(negedge clk);
    chk("t5_halt", {31'd0, halt}, 32'd1);
    chk("t5_nobyp", ra, 32'd0);
    c0 = m_cycles;
    repeat (5) step();
    @(negedge clk);
    chk("t5_frozen", cyc_o, c0);
    chk("t5_nowrite", ra, 32'd0);
    chk("t5_disp_hold", disp, 32'hBEEF);
    step();
    do_reset();

    // T6 stall, bubble, counter wrap
    en = 1'b0;
    set(23'h1, 1, 3, 32'h77, 0, 0, 3, 0);
    repeat (16) step();
    @(negedge clk);
    chk("t6_cycles", cyc_o, 32'd16);
    chk("t6_wrap4", {28'd0, cyc4}, 32'd0);
    chk("t6_stall_ret", ret_o, 32'd0);
    chk("t6_stall_wr", ra, 32'd0);
    en = 1'b1;
    set(23'h1, 0, 3, 32'h77, 0, 0, 3, 0);
    step();
    @(negedge clk);
    chk("t6_bubble_ret", ret_o, 32'd0);
    chk("t6_bubble_wr", ra, 32'd0);
    step();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [22:0] c;
      c = 23'($urandom);
      c[0] = ($urandom_range(0, 3) != 0);
      c[2] = ($urandom_range(0, 7) == 0);
      c[3] = ($urandom_range(0, 15) == 0);
      clr = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 7) != 0);
      set(c,
          ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom | 32'd1,
          5'($urandom),
          ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15))
                                      : $urandom,
          $urandom, $urandom,
          ($urandom_range(0, 3) == 0) ? p4 : 5'($urandom),
          5'($urandom));
      if ($urandom_range(0, 2) == 0) rd_b = p4;
      step();
    end
    clr = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule
